// File: rtl/seg_disp_arb.sv
// seg_disp_arb: chooses what the 4-digit seven-segment scanner shows.
// Sources are the live elevator status, one-shot requester messages
// (held for HOLD_TICKS cycles, optionally blinking) and an alarm code
// that pre-empts everything. All outputs are registered.
module seg_disp_arb #(
  parameter int          HOLD_TICKS = 380,
  parameter int          BLINK_HALF = 48,
  parameter logic [3:0]  BLINK_CODE = 4'd15
) (
  input  logic        clk190hz,
  input  logic        rst_n,
  input  logic [3:0]  st_floor,
  input  logic [3:0]  st_status,
  input  logic [3:0]  st_pstate,
  input  logic [3:0]  st_door,
  input  logic        msg_req,
  input  logic [15:0] msg_data,
  input  logic        msg_urgent,
  output logic        msg_ack,
  output logic        msg_busy,
  input  logic        alarm,
  input  logic [3:0]  alarm_code,
  output logic [3:0]  floor,
  output logic [3:0]  status,
  output logic [3:0]  pstate,
  output logic [3:0]  door,
  output logic [1:0]  page
);

  typedef enum logic [1:0] {
    S_LIVE  = 2'd0,
    S_MSG   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  localparam int TW = $clog2(HOLD_TICKS);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [15:0]   r_msg_data;
  logic          r_msg_urgent;
  logic          r_ack;
  logic [15:0]   r_digits;

  state_t        w_state_next;
  logic [TW-1:0] w_timer_next;
  logic [BW-1:0] w_blink_cnt_next;
  logic          w_phase_next;
  logic [15:0]   w_msg_data_next;
  logic          w_msg_urgent_next;
  logic          w_ack_next;
  logic [15:0]   w_digits_next;

  logic [15:0]   w_live_word;
  logic [15:0]   w_alarm_word;
  logic [15:0]   w_blink_word;
  logic          w_blink_wrap;
  logic [BW-1:0] w_blink_cnt_adv;
  logic          w_phase_adv;

  assign w_live_word = {st_floor, st_status, st_pstate, st_door};

  // Replicate the alarm code and blink code across all four digits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit_fill
      assign w_alarm_word[gi*4 +: 4] = alarm_code;
      assign w_blink_word[gi*4 +: 4] = BLINK_CODE;
    end
  endgenerate

  // Blink counter advance: wrap at the half-period and flip the phase.
  assign w_blink_wrap    = (r_blink_cnt == BLINK_LAST);
  assign w_blink_cnt_adv = w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
  assign w_phase_adv     = r_phase ^ w_blink_wrap;

  // Next-state and next-output decode; alarm always wins, then requests.
  always_comb begin
    w_state_next      = r_state;
    w_timer_next      = r_timer;
    w_blink_cnt_next  = r_blink_cnt;
    w_phase_next      = r_phase;
    w_msg_data_next   = r_msg_data;
    w_msg_urgent_next = r_msg_urgent;
    w_ack_next        = 1'b0;
    w_digits_next     = w_live_word;
    case (r_state)
      S_LIVE: begin
        w_timer_next     = '0;
        w_blink_cnt_next = '0;
        w_phase_next     = 1'b0;
        if (alarm) begin
          w_state_next  = S_ALARM;
          w_digits_next = w_alarm_word;
        end else if (msg_req) begin
          w_state_next      = S_MSG;
          w_msg_data_next   = msg_data;
          w_msg_urgent_next = msg_urgent;
          w_ack_next        = 1'b1;
          w_digits_next     = msg_data;
        end
      end
      S_MSG: begin
        if (alarm) begin
          // Message is dropped for good; alarm blink starts fresh.
          w_state_next     = S_ALARM;
          w_timer_next     = '0;
          w_blink_cnt_next = '0;
          w_phase_next     = 1'b0;
          w_digits_next    = w_alarm_word;
        end else if (r_timer == TIMER_LAST) begin
          w_state_next     = S_LIVE;
          w_timer_next     = '0;
          w_blink_cnt_next = '0;
          w_phase_next     = 1'b0;
        end else begin
          w_timer_next     = r_timer + TW'(1);
          w_blink_cnt_next = w_blink_cnt_adv;
          w_phase_next     = w_phase_adv;
          w_digits_next    = (r_msg_urgent && w_phase_adv) ? w_blink_word : r_msg_data;
        end
      end
      S_ALARM: begin
        if (!alarm) begin
          w_state_next     = S_LIVE;
          w_timer_next     = '0;
          w_blink_cnt_next = '0;
          w_phase_next     = 1'b0;
        end else begin
          w_blink_cnt_next = w_blink_cnt_adv;
          w_phase_next     = w_phase_adv;
          w_digits_next    = w_phase_adv ? w_blink_word : w_alarm_word;
        end
      end
      default: begin
        w_state_next     = S_LIVE;
        w_timer_next     = '0;
        w_blink_cnt_next = '0;
        w_phase_next     = 1'b0;
      end
    endcase
  end

  // State, counters, latched message and registered display outputs.
  always_ff @(posedge clk190hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LIVE;
      r_timer      <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_msg_data   <= '0;
      r_msg_urgent <= 1'b0;
      r_ack        <= 1'b0;
      r_digits     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_blink_cnt  <= w_blink_cnt_next;
      r_phase      <= w_phase_next;
      r_msg_data   <= w_msg_data_next;
      r_msg_urgent <= w_msg_urgent_next;
      r_ack        <= w_ack_next;
      r_digits     <= w_digits_next;
    end
  end

  assign floor    = r_digits[15:12];
  assign status   = r_digits[11:8];
  assign pstate   = r_digits[7:4];
  assign door     = r_digits[3:0];
  assign msg_ack  = r_ack;
  assign msg_busy = (r_state != S_LIVE);
  assign page     = r_state;

endmodule

// File: tb/tb_seg_disp_arb.sv
// Bench for seg_disp_arb: a cycle-age model of the display pages checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_seg_disp_arb;
  localparam int         HOLD = 8;
  localparam int         BH   = 2;
  localparam logic [3:0] BC   = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  st_floor, st_status, st_pstate, st_door;
  logic        msg_req, msg_urgent, alarm;
  logic [15:0] msg_data;
  logic [3:0]  alarm_code;
  logic        msg_ack, msg_busy;
  logic [3:0]  floor, status, pstate, door;
  logic [1:0]  page;

  seg_disp_arb #(.HOLD_TICKS(HOLD), .BLINK_HALF(BH), .BLINK_CODE(BC)) dut (
    .clk190hz(clk), .rst_n(rst_n),
    .st_floor(st_floor), .st_status(st_status), .st_pstate(st_pstate), .st_door(st_door),
    .msg_req(msg_req), .msg_data(msg_data), .msg_urgent(msg_urgent),
    .msg_ack(msg_ack), .msg_busy(msg_busy),
    .alarm(alarm), .alarm_code(alarm_code),
    .floor(floor), .status(status), .pstate(pstate), .door(door), .page(page)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: mode plus age in cycles since entering that mode.
  // 0 = live, 1 = message, 2 = alarm.
  int          m_mode, m_age;
  logic [15:0] m_data;
  logic        m_urg;
  logic [15:0] e_dig;
  logic        e_ack;
  logic [1:0]  e_page;

  always @(posedge clk or negedge rst_n) begin : model
    int          nm, na;
    logic [15:0] nd, show;
    logic        nu, nack;
    if (!rst_n) begin
      m_mode <= 0; m_age <= 0; m_data <= '0; m_urg <= 1'b0;
      e_dig <= '0; e_ack <= 1'b0; e_page <= 2'd0;
    end else begin
      nm = m_mode; na = m_age + 1; nd = m_data; nu = m_urg; nack = 1'b0;
      case (m_mode)
        0: begin
          na = 0;
          if (alarm) nm = 2;
          else if (msg_req) begin
            nm = 1; nd = msg_data; nu = msg_urgent; nack = 1'b1;
          end
        end
        1: begin
          if (alarm) begin nm = 2; na = 0; end
          else if (na == HOLD) begin nm = 0; na = 0; end
        end
        default: if (!alarm) begin nm = 0; na = 0; end
      endcase
      case (nm)
        0:       show = {st_floor, st_status, st_pstate, st_door};
        1:       show = (nu && ((na / BH) % 2 == 1)) ? {4{BC}} : nd;
        default: show = ((na / BH) % 2 == 1) ? {4{BC}} : {4{alarm_code}};
      endcase
      m_mode <= nm; m_age <= na; m_data <= nd; m_urg <= nu;
      e_dig <= show; e_ack <= nack; e_page <= 2'(nm);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_digits", {floor, status, pstate, door}, e_dig);
    chk("model_page", {14'd0, page}, {14'd0, e_page});
    chk("model_busy", {15'd0, msg_busy}, {15'd0, (e_page != 2'd0)});
    chk("model_ack", {15'd0, msg_ack}, {15'd0, e_ack});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_live(input logic [15:0] v);
    {st_floor, st_status, st_pstate, st_door} = v;
  endtask

  function automatic logic [15:0] dig();
    return {floor, status, pstate, door};
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] pat [8];
    int c1;
    pat[0] = 16'h5678; pat[1] = 16'h5678; pat[2] = 16'hFFFF; pat[3] = 16'hFFFF;
    pat[4] = 16'h5678; pat[5] = 16'h5678; pat[6] = 16'hFFFF; pat[7] = 16'hFFFF;
    rst_n = 1'b1; msg_req = 1'b0; msg_urgent = 1'b0; alarm = 1'b0;
    msg_data = '0; alarm_code = '0; set_live(16'h0000);
    #1 rst_n = 1'b0;
    tick(2);
    chk("reset_digits", dig(), 16'h0000);
    chk("reset_page", {14'd0, page}, 16'd0);
    #2 rst_n = 1'b1;

    // Live passthrough, one cycle latency.
    set_live(16'h3567);
    tick(1);
    chk("live_pass", dig(), 16'h3567);

    // Normal message: visible for exactly HOLD cycles.
    msg_req = 1'b1; msg_data = 16'h1234; msg_urgent = 1'b0;
    tick(1);
    chk("norm_ack", {15'd0, msg_ack}, 16'd1);
    chk("norm_first", dig(), 16'h1234);
    msg_req = 1'b0;
    tick(HOLD - 1);
    chk("norm_last", dig(), 16'h1234);
    tick(1);
    chk("norm_back_live", dig(), 16'h3567);
    chk("norm_page0", {14'd0, page}, 16'd0);

    // Urgent blinking message.
    tick(1);
    msg_req = 1'b1; msg_data = 16'h5678; msg_urgent = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (i == 0) msg_req = 1'b0;
      chk($sformatf("urgent_%0d", i), dig(), pat[i]);
    end
    tick(1);
    chk("urgent_live", dig(), 16'h3567);

    // Alarm pre-empts at the third message cycle.
    msg_req = 1'b1; msg_data = 16'h1234; msg_urgent = 1'b0;
    tick(1);
    msg_req = 1'b0;
    tick(1);
    alarm = 1'b1; alarm_code = 4'd9;
    tick(1);
    chk("preempt_code", dig(), 16'h9999);
    chk("preempt_page", {14'd0, page}, 16'd2);
    tick(2);
    chk("alarm_blink", dig(), 16'hFFFF);
    tick(1);
    alarm = 1'b0; set_live(16'h2468);
    tick(1);
    chk("alarm_exit_live", dig(), 16'h2468);
    tick(4);
    chk("no_replay", dig(), 16'h2468);

    // Simultaneous alarm and request in LIVE.
    alarm = 1'b1; alarm_code = 4'd2; msg_req = 1'b1; msg_data = 16'hABCD;
    tick(1);
    chk("simul_page", {14'd0, page}, 16'd2);
    chk("simul_noack", {15'd0, msg_ack}, 16'd0);
    tick(3);
    alarm = 1'b0;
    tick(1);
    chk("simul_live_noack", {15'd0, msg_ack}, 16'd0);
    tick(1);
    chk("simul_late_ack", {15'd0, msg_ack}, 16'd1);
    chk("simul_msg", dig(), 16'hABCD);
    msg_req = 1'b0;
    tick(HOLD + 1);

    // Held request: second ack exactly HOLD+1 cycles after the first.
    msg_req = 1'b1; msg_data = 16'h4321;
    tick(1);
    chk("held_ack1", {15'd0, msg_ack}, 16'd1);
    c1 = cyc;
    tick(HOLD + 1);
    chk("held_ack2", {15'd0, msg_ack}, 16'd1);
    chk("held_gap", 16'(cyc - c1), 16'(HOLD + 1));
    msg_req = 1'b0;
    tick(HOLD + 1);

    // Reset in the middle of a message.
    msg_req = 1'b1; msg_data = 16'h9ABC;
    tick(1);
    msg_req = 1'b0;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_digits", dig(), 16'h0000);
    chk("rst_mid_page", {14'd0, page}, 16'd0);
    chk("rst_mid_busy", {15'd0, msg_busy}, 16'd0);
    @(negedge clk);
    #2 rst_n = 1'b1; set_live(16'h8765);
    tick(1);
    chk("rst_release_live", dig(), 16'h8765);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
